// File: rtl/clahe_hist_sdp_ctrl_pkg.sv
// Shared definitions for the CLAHE histogram controller: state encoding
// and default parameter values.
package clahe_hist_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_RD_LAT     = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_READOUT = 3'd4
    } state_t;

endpackage

// File: rtl/clahe_hist_sdp_ctrl_fwd.sv
// Write-history for read-after-write forwarding. It keeps the last DEPTH
// RAM writes and compares them, plus the write being issued right now,
// against the bin whose increment is being resolved. The newest match wins.
module clahe_hist_fwd
    import clahe_hist_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);

    logic [DEPTH-1:0]      hist_v_r;
    logic [ADDR_WIDTH-1:0] hist_addr_r [DEPTH];
    logic [DATA_WIDTH-1:0] hist_data_r [DEPTH];

    // Shift every issued write into the history; entry 0 is the most recent.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_v_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                hist_addr_r[k] <= '0;
                hist_data_r[k] <= '0;
            end
        end else begin
            hist_v_r[0]    <= wr_en;
            hist_addr_r[0] <= wr_addr;
            hist_data_r[0] <= wr_data;
            for (int k = 1; k < DEPTH; k++) begin
                hist_v_r[k]    <= hist_v_r[k-1];
                hist_addr_r[k] <= hist_addr_r[k-1];
                hist_data_r[k] <= hist_data_r[k-1];
            end
        end
    end

    // Scan oldest to newest so a younger match overrides an older one; the
    // write on the port this cycle is younger than anything in the history.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hist_v_r[k] && (hist_addr_r[k] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = hist_data_r[k];
            end else begin
                hit      = hit;
                hit_data = hit_data;
            end
        end
        if (wr_en && (wr_addr == lookup_addr)) begin
            hit      = 1'b1;
            hit_data = wr_data;
        end else begin
            hit      = hit;
            hit_data = hit_data;
        end
    end

endmodule

// File: rtl/clahe_hist_sdp_ctrl.sv
// CLAHE histogram controller on a simple dual-port RAM: clears the bins,
// accumulates pixel counts with a read-modify-write pipeline, then reads
// every bin out in ascending order.
module clahe_hist_sdp_ctrl
    import clahe_hist_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [ADDR_WIDTH-1:0] pix_bin,
    output logic                  pix_ready,
    input  logic                  frame_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_MAX = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Saturating +1 so a full bin sticks at its maximum instead of wrapping.
    function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
        if (v == DATA_MAX) begin
            sat_inc = DATA_MAX;
        end else begin
            sat_inc = v + DATA_ONE;
        end
    endfunction

    state_t                state_r;
    logic                  ro_re_r;
    logic [ADDR_WIDTH-1:0] ro_addr_r;
    logic [RD_LAT-1:0]     pipe_inc_r;
    logic [RD_LAT-1:0]     pipe_ro_r;
    logic [ADDR_WIDTH-1:0] pipe_addr_r [RD_LAT];

    logic                  accept_s;
    logic                  fwd_hit_s;
    logic [DATA_WIDTH-1:0] fwd_data_s;
    logic [DATA_WIDTH-1:0] cur_cnt_s;
    logic [DATA_WIDTH-1:0] next_cnt_s;
    logic [ADDR_WIDTH-1:0] wb_addr_s;

    // Reads go out in the same cycle a pixel is taken (or a readout bin is due),
    // and the pipeline tail lines up with ram_rdata RD_LAT cycles later.
    assign accept_s   = pix_valid & pix_ready;
    assign ram_re     = accept_s | ro_re_r;
    assign ram_raddr  = ro_re_r ? ro_addr_r : (accept_s ? pix_bin : '0);
    assign wb_addr_s  = pipe_addr_r[RD_LAT-1];
    assign cur_cnt_s  = fwd_hit_s ? fwd_data_s : ram_rdata;
    assign next_cnt_s = sat_inc(cur_cnt_s);
    assign out_valid  = pipe_ro_r[RD_LAT-1];
    assign out_addr   = pipe_addr_r[RD_LAT-1];
    assign out_data   = out_valid ? ram_rdata : '0;

    clahe_hist_fwd #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RD_LAT)
    ) u_fwd (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (ram_we),
        .wr_addr     (ram_waddr),
        .wr_data     (ram_wdata),
        .lookup_addr (wb_addr_s),
        .hit         (fwd_hit_s),
        .hit_data    (fwd_data_s)
    );

    // Track each outstanding read (increment or readout) until its data returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_inc_r <= '0;
            pipe_ro_r  <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_addr_r[k] <= '0;
            end
        end else begin
            pipe_inc_r[0]  <= accept_s;
            pipe_ro_r[0]   <= ro_re_r;
            pipe_addr_r[0] <= ram_raddr;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_inc_r[k]  <= pipe_inc_r[k-1];
                pipe_ro_r[k]   <= pipe_ro_r[k-1];
                pipe_addr_r[k] <= pipe_addr_r[k-1];
            end
        end
    end

    // Control FSM with registered write port, readout sequencer and status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ro_re_r   <= 1'b0;
            ro_addr_r <= '0;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Increment write-back; only ever active in ACCUM/DRAIN.
            if (pipe_inc_r[RD_LAT-1]) begin
                ram_we    <= 1'b1;
                ram_waddr <= wb_addr_s;
                ram_wdata <= next_cnt_s;
            end else begin
                ram_we    <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_CLEAR;
                        busy      <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_waddr <= '0;
                        ram_wdata <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (ram_waddr == ADDR_MAX) begin
                        state_r   <= ST_ACCUM;
                        pix_ready <= 1'b1;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_waddr <= ram_waddr + ADDR_ONE;
                    end
                end
                ST_ACCUM: begin
                    if (frame_done) begin
                        state_r   <= ST_DRAIN;
                        pix_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if ((pipe_inc_r == '0) && !ram_we) begin
                        state_r   <= ST_READOUT;
                        ro_re_r   <= 1'b1;
                        ro_addr_r <= '0;
                    end
                end
                ST_READOUT: begin
                    if (ro_re_r) begin
                        if (ro_addr_r == ADDR_MAX) begin
                            ro_re_r   <= 1'b0;
                        end else begin
                            ro_addr_r <= ro_addr_r + ADDR_ONE;
                        end
                    end
                    if (!ro_re_r && out_valid && (out_addr == ADDR_MAX)) begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        ro_addr_r <= '0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    pix_ready <= 1'b0;
                    ro_re_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clahe_hist_sdp_ctrl.sv
// Directed bench for clahe_hist_sdp_ctrl. Two instances share the stimulus:
// A (16-bit bins, RD_LAT=2) and B (4-bit bins, RD_LAT=1), each with its own
// behavioural RAM model that returns the pre-write value on a same-cycle
// read/write.
module tb_clahe_hist_sdp_ctrl;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic pix_valid = 1'b0;
    logic frame_done = 1'b0;
    logic [AW-1:0] pix_bin = '0;

    logic pix_ready_a, ram_we_a, ram_re_a, out_valid_a, busy_a;
    logic [AW-1:0] ram_waddr_a, ram_raddr_a, out_addr_a;
    logic [15:0] ram_wdata_a, ram_rdata_a, out_data_a;

    logic pix_ready_b, ram_we_b, ram_re_b, out_valid_b, busy_b;
    logic [AW-1:0] ram_waddr_b, ram_raddr_b, out_addr_b;
    logic [3:0] ram_wdata_b, ram_rdata_b, out_data_b;

    logic [15:0] mem_a [16];
    logic [15:0] rd_a1, rd_a2;
    logic [3:0]  mem_b [16];
    logic [3:0]  rd_b1;

    logic [15:0] exp_a [16];
    logic [3:0]  exp_b [16];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    clahe_hist_sdp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .RD_LAT(2)) u_a (
        .clk(clk), .rstn(rstn), .start(start), .pix_valid(pix_valid), .pix_bin(pix_bin),
        .pix_ready(pix_ready_a), .frame_done(frame_done), .ram_we(ram_we_a),
        .ram_waddr(ram_waddr_a), .ram_wdata(ram_wdata_a), .ram_re(ram_re_a),
        .ram_raddr(ram_raddr_a), .ram_rdata(ram_rdata_a), .out_valid(out_valid_a),
        .out_addr(out_addr_a), .out_data(out_data_a), .busy(busy_a)
    );

    clahe_hist_sdp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(4), .RD_LAT(1)) u_b (
        .clk(clk), .rstn(rstn), .start(start), .pix_valid(pix_valid), .pix_bin(pix_bin),
        .pix_ready(pix_ready_b), .frame_done(frame_done), .ram_we(ram_we_b),
        .ram_waddr(ram_waddr_b), .ram_wdata(ram_wdata_b), .ram_re(ram_re_b),
        .ram_raddr(ram_raddr_b), .ram_rdata(ram_rdata_b), .out_valid(out_valid_b),
        .out_addr(out_addr_b), .out_data(out_data_b), .busy(busy_b)
    );

    // RAM model A: two-cycle read latency.
    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_waddr_a] <= ram_wdata_a;
        rd_a1 <= ram_re_a ? mem_a[ram_raddr_a] : 16'hdead;
        rd_a2 <= rd_a1;
    end
    assign ram_rdata_a = rd_a2;

    // RAM model B: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we_b) mem_b[ram_waddr_b] <= ram_wdata_b;
        rd_b1 <= ram_re_b ? mem_b[ram_raddr_b] : 4'hd;
    end
    assign ram_rdata_b = rd_b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl_a"}, {ram_we_a, ram_re_a, pix_ready_a, out_valid_a, busy_a,
                              ram_waddr_a, ram_raddr_a, out_addr_a}, 32'd0);
        chk({tag, "_dat_a"}, {ram_wdata_a, out_data_a}, 32'd0);
        chk({tag, "_ctl_b"}, {ram_we_b, ram_re_b, pix_ready_b, out_valid_b, busy_b,
                              ram_waddr_b, ram_raddr_b, out_addr_b}, 32'd0);
        chk({tag, "_dat_b"}, {ram_wdata_b, out_data_b}, 32'd0);
    endtask

    task automatic px(input logic [AW-1:0] b, input logic fd);
        @(negedge clk);
        pix_valid  = 1'b1;
        pix_bin    = b;
        frame_done = fd;
    endtask

    task automatic end_frame;
        @(negedge clk);
        pix_valid  = 1'b0;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic do_start;
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(pix_ready_a && pix_ready_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_to_accum", {31'd0, pix_ready_a & pix_ready_b}, 32'd1);
    endtask

    task automatic clear_exp;
        for (int i = 0; i < 16; i++) begin
            exp_a[i] = 16'd0;
            exp_b[i] = 4'd0;
        end
    endtask

    task automatic wait_readout(input bit poke);
        int n;
        int cnt_a;
        int cnt_b;
        bit poked;
        n = 0; cnt_a = 0; cnt_b = 0; poked = 1'b0;
        while ((busy_a || busy_b) && n < 400) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (out_valid_a) begin
                chk("ro_addr_a", {28'd0, out_addr_a}, cnt_a);
                chk("ro_data_a", {16'd0, out_data_a}, {16'd0, exp_a[out_addr_a]});
                cnt_a++;
                if (poke && !poked) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
            end else if (cnt_a > 0 && cnt_a < 16) begin
                chk("ro_contig_a", {31'd0, out_valid_a}, 32'd1);
            end
            if (out_valid_b) begin
                chk("ro_addr_b", {28'd0, out_addr_b}, cnt_b);
                chk("ro_data_b", {28'd0, out_data_b}, {28'd0, exp_b[out_addr_b]});
                cnt_b++;
            end else if (cnt_b > 0 && cnt_b < 16) begin
                chk("ro_contig_b", {31'd0, out_valid_b}, 32'd1);
            end
        end
        start = 1'b0;
        chk("ro_timeout", {31'd0, n < 400}, 32'd1);
        chk("ro_count_a", cnt_a, 32'd16);
        chk("ro_count_b", cnt_b, 32'd16);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rstn = 1'b1;

        // Start: 16 clear writes of 0 at 0..15 on consecutive cycles, then ACCUM
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("clear_we", {ram_we_a, ram_we_b}, 32'd3);
            chk("clear_addr_a", {28'd0, ram_waddr_a}, i);
            chk("clear_addr_b", {28'd0, ram_waddr_b}, i);
            chk("clear_data", {ram_wdata_a, ram_wdata_b}, 32'd0);
            chk("clear_ready", {pix_ready_a, pix_ready_b}, 32'd0);
            @(negedge clk);
        end
        chk("accum_ready", {pix_ready_a, pix_ready_b, ram_we_a, ram_we_b}, 32'd12);
        chk("accum_busy", {busy_a, busy_b}, 32'd3);

        // Frame 1: ten pixels into bin 3
        for (int i = 0; i < 10; i++) px(4'd3, 1'b0);
        end_frame();
        clear_exp();
        exp_a[3] = 16'd10;
        exp_b[3] = 4'd10;
        wait_readout(1'b0);

        // Frame 2: 5,6,5,6,5 back-to-back, the last pixel with frame_done;
        // start pulsed during READOUT must be ignored
        do_start();
        px(4'd5, 1'b0);
        px(4'd6, 1'b0);
        px(4'd5, 1'b0);
        px(4'd6, 1'b0);
        px(4'd5, 1'b1);
        @(negedge clk);
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        clear_exp();
        exp_a[5] = 16'd3;
        exp_a[6] = 16'd2;
        exp_b[5] = 4'd3;
        exp_b[6] = 4'd2;
        wait_readout(1'b1);
        repeat (3) @(negedge clk);
        chk("start_in_readout_ignored", {busy_a, busy_b, ram_we_a, ram_we_b, ram_re_a, ram_re_b}, 32'd0);

        // Frame 3: twenty pixels into bin 0; B saturates at 15
        do_start();
        for (int i = 0; i < 20; i++) px(4'd0, 1'b0);
        end_frame();
        clear_exp();
        exp_a[0] = 16'd20;
        exp_b[0] = 4'd15;
        wait_readout(1'b0);

        // Reset in the middle of ACCUM with increments in flight
        do_start();
        px(4'd3, 1'b0);
        px(4'd3, 1'b0);
        px(4'd7, 1'b0);
        @(negedge clk);
        rstn      = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge clk);
        chk_reset("midreset_hold");
        rstn = 1'b1;

        // Restart after reset clears and counts correctly
        do_start();
        px(4'd1, 1'b0);
        px(4'd1, 1'b0);
        px(4'd2, 1'b0);
        end_frame();
        clear_exp();
        exp_a[1] = 16'd2;
        exp_a[2] = 16'd1;
        exp_b[1] = 4'd2;
        exp_b[2] = 4'd1;
        wait_readout(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
